// File: rtl/prog_loader_if.sv
// Program-stream and instruction-memory write bundle for prog_loader.
// slave  : the loader (accepts the word stream, drives the memory write port)
// master : the program source / memory side
interface prog_loader_if #(
   parameter int D = 10,
   parameter int W = 9
);
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         in_ready;
   logic         wr_en;
   logic [D-1:0] wr_addr;
   logic [W-1:0] wr_data;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, then releases the
// CPU from reset and counts its run cycles until it reports done.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum word (CHECK state) before the CPU is released.
// Every output is a register; status flags are decoded from the next state so
// they line up exactly with the state register.
module prog_loader #(
   parameter int D = 10,
   parameter int W = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   prog_loader_if.slave  bus,
   output logic          cpu_reset,
   input  logic          cpu_done,
   output logic          busy,
   output logic          finished,
   output logic          error,
   output logic [D:0]    prog_len,
   output logic [15:0]   cycles
);

`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;
`endif

   localparam logic [D-1:0] ADDR_MAX = '1;
   localparam logic [D-1:0] ADDR_ONE = D'(1);
   localparam logic [D:0]   LEN_ONE  = (D + 1)'(1);
   localparam logic [15:0]  CYC_MAX  = 16'hFFFF;

   state_t       state_reg,     state_next;
   logic [D-1:0] addr_reg,      addr_next;
   logic [D:0]   prog_len_reg,  prog_len_next;
   logic [15:0]  cycles_reg,    cycles_next;
   logic         wr_en_reg,     wr_en_next;
   logic [D-1:0] wr_addr_reg,   wr_addr_next;
   logic [W-1:0] wr_data_reg,   wr_data_next;
   logic         in_ready_reg,  in_ready_next;
   logic         cpu_reset_reg, cpu_reset_next;
   logic         busy_reg,      busy_next;
   logic         finished_reg,  finished_next;
   logic         error_reg,     error_next;
   logic         xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [W-1:0] chk_reg,       chk_next;
`endif

   // state and datapath registers; reset abandons any load or run in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         prog_len_reg  <= '0;
         cycles_reg    <= '0;
         wr_en_reg     <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
         in_ready_reg  <= 1'b0;
         cpu_reset_reg <= 1'b1;
         busy_reg      <= 1'b0;
         finished_reg  <= 1'b0;
         error_reg     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         chk_reg       <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         prog_len_reg  <= prog_len_next;
         cycles_reg    <= cycles_next;
         wr_en_reg     <= wr_en_next;
         wr_addr_reg   <= wr_addr_next;
         wr_data_reg   <= wr_data_next;
         in_ready_reg  <= in_ready_next;
         cpu_reset_reg <= cpu_reset_next;
         busy_reg      <= busy_next;
         finished_reg  <= finished_next;
         error_reg     <= error_next;
`ifdef PROG_LOADER_CHECKSUM_EN
         chk_reg       <= chk_next;
`endif
      end
   end

   // next-state and datapath updates; in_ready_reg is high exactly in the
   // accepting states, so xfer is the real handshake
   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      prog_len_next = prog_len_reg;
      cycles_next   = cycles_reg;
      wr_en_next    = 1'b0;
      wr_addr_next  = wr_addr_reg;
      wr_data_next  = wr_data_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_next      = chk_reg;
`endif
      xfer          = bus.in_valid && in_ready_reg;

      case (state_reg)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_next    = LOAD;
               addr_next     = '0;
               prog_len_next = '0;
               cycles_next   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               chk_next      = '0;
`endif
            end
         end

         LOAD: begin
            if (xfer) begin
               wr_en_next    = 1'b1;
               wr_addr_next  = addr_reg;
               wr_data_next  = bus.in_data;
               prog_len_next = prog_len_reg + LEN_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
               chk_next      = chk_reg ^ bus.in_data;
`endif
               // the counter parks at the top address instead of wrapping
               if (addr_reg != ADDR_MAX) begin
                  addr_next = addr_reg + ADDR_ONE;
               end
               if (bus.in_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state_next = CHECK;
`else
                  state_next = RUN;
`endif
               end else if (addr_reg == ADDR_MAX) begin
                  state_next = ERR;
               end
            end
         end

`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            // the checksum word is compared only, never written
            if (xfer) begin
               state_next = (bus.in_data == chk_reg) ? RUN : ERR;
            end
         end
`endif

         RUN: begin
            if (cycles_reg != CYC_MAX) begin
               cycles_next = cycles_reg + 16'd1;
            end
            if (cpu_done && !cpu_reset_reg) begin
               state_next = DONE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // status flags decoded from the next state so they register with it
   always_comb begin
      in_ready_next  = 1'b0;
      busy_next      = 1'b0;
      cpu_reset_next = 1'b1;
      finished_next  = 1'b0;
      error_next     = 1'b0;
      case (state_next)
         LOAD: begin
            in_ready_next = 1'b1;
            busy_next     = 1'b1;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            in_ready_next = 1'b1;
            busy_next     = 1'b1;
         end
`endif
         RUN: begin
            busy_next      = 1'b1;
            cpu_reset_next = 1'b0;
         end
         DONE: begin
            finished_next = 1'b1;
         end
         ERR: begin
            error_next = 1'b1;
         end
         default: begin
            in_ready_next = 1'b0;
         end
      endcase
   end

   assign bus.in_ready = in_ready_reg;
   assign bus.wr_en    = wr_en_reg;
   assign bus.wr_addr  = wr_addr_reg;
   assign bus.wr_data  = wr_data_reg;
   assign cpu_reset    = cpu_reset_reg;
   assign busy         = busy_reg;
   assign finished     = finished_reg;
   assign error        = error_reg;
   assign prog_len     = prog_len_reg;
   assign cycles       = cycles_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the stimulus side pushes every expected
// memory write, independent monitors pop and compare on each wr_en pulse.
// A second instance with D=3 covers address overflow.
// Follows PROG_LOADER_CHECKSUM_EN the same way the design does.
module tb_prog_loader;
   localparam int D  = 10;
   localparam int W  = 9;
   localparam int DS = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, cpu_done;
   logic          cpu_reset, busy, finished, error;
   logic [D:0]    prog_len;
   logic [15:0]   cycles;
   logic          start_s, cpu_done_s;
   logic          cpu_reset_s, busy_s, finished_s, error_s;
   logic [DS:0]   prog_len_s;
   logic [15:0]   cycles_s;

   prog_loader_if #(.D(D),  .W(W)) bus   ();
   prog_loader_if #(.D(DS), .W(W)) bus_s ();

   prog_loader #(.D(D), .W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .cpu_reset(cpu_reset), .cpu_done(cpu_done), .busy(busy),
      .finished(finished), .error(error), .prog_len(prog_len), .cycles(cycles)
   );

   prog_loader #(.D(DS), .W(W)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .bus(bus_s),
      .cpu_reset(cpu_reset_s), .cpu_done(cpu_done_s), .busy(busy_s),
      .finished(finished_s), .error(error_s), .prog_len(prog_len_s), .cycles(cycles_s)
   );

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   wr_t exp_s[$];
   wr_t mon_e, mon_es;
   int  checks = 0;
   int  errors = 0;
   int  model_addr = 0;
   int  run_low = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // main monitor: every write must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (cpu_reset === 1'b0) run_low++;
      if (bus.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write: wr_en=1 addr=%0h data=%0h, expected no write", bus.wr_addr, bus.wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
            chk("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
            $display("write addr=%0h data=%03h", bus.wr_addr, bus.wr_data);
         end
      end
   end

   // overflow-instance monitor
   always @(negedge clk) begin
      if (bus_s.wr_en === 1'b1) begin
         if (exp_s.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_write_small: wr_en=1 addr=%0h, expected no write", bus_s.wr_addr);
         end else begin
            mon_es = exp_s.pop_front();
            chk("small_wr_addr", 64'(bus_s.wr_addr), 64'(mon_es.addr));
            chk("small_wr_data", 64'(bus_s.wr_data), 64'(mon_es.data));
            $display("small write addr=%0h data=%03h", bus_s.wr_addr, bus_s.wr_data);
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      start        = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start        = 1'b1;
      bus.in_valid = 1'b0;
      model_addr   = 0;
      run_low      = 0;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy",     64'(busy),         64'd1);
      chk("start_in_ready", 64'(bus.in_ready), 64'd1);
      chk("start_prog_len", 64'(prog_len),     64'd0);
      chk("start_cycles",   64'(cycles),       64'd0);
      chk("start_error",    64'(error),        64'd0);
   endtask

   // present one word until accepted; optional random idle gaps and ignored start pulses
   task automatic send_word(input int data, input bit last, input int gap_pct,
                            input bit toggle, input bit no_push);
      bit done  = 1'b0;
      bit skip  = toggle;
      int tries = 0;
      while (!done) begin
         @(negedge clk);
         start = 1'b0;
         if (skip || ($urandom_range(99) < gap_pct)) begin
            bus.in_valid = 1'b0;
            skip = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(data);
            bus.in_last  = last;
            if ($urandom_range(9) == 0) start = 1'b1;
            if (bus.in_ready === 1'b1) begin
               if (!no_push) begin
                  exp_q.push_back('{model_addr, data});
                  model_addr++;
               end
               done = 1'b1;
            end
         end
         tries++;
         if (!done && tries > 60) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready=%0b, expected 1 within 60 cycles", bus.in_ready);
            done = 1'b1;
         end
      end
   endtask

   task automatic load_program(input int words[$], input int gap, input bit toggle);
`ifdef PROG_LOADER_CHECKSUM_EN
      int x = 0;
      foreach (words[i]) x ^= words[i];
`endif
      do_start();
      foreach (words[i]) send_word(words[i], (i == words.size() - 1), gap, toggle, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(x, 1'(($urandom_range(1))), gap, 1'b0, 1'b1);
`endif
      idle();
   endtask

   // expects to be called at a negedge at or shortly before the first RUN cycle
   task automatic run_cpu(input int k, input int exp_len);
      int waited = 0;
      while (cpu_reset !== 1'b0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("enter_run", 64'(cpu_reset), 64'd0);
      repeat (k - 1) @(negedge clk);
      cpu_done = 1'b1;
      @(negedge clk);
      cpu_done = 1'b0;
      chk("done_finished",  64'(finished),  64'd1);
      chk("done_busy",      64'(busy),      64'd0);
      chk("done_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("done_cycles",    64'(cycles),    64'(k));
      chk("done_prog_len",  64'(prog_len),  64'(exp_len));
      chk("run_cycles_seen", 64'(run_low),  64'(k));
      $display("run done: len=%0d cycles=%0d expected %0d", prog_len, cycles, k);
   endtask

`ifdef PROG_LOADER_CHECKSUM_EN
   task automatic checksum_case(input int ck, input bit expect_ok);
      do_start();
      send_word(9'h1A5, 1'b0, 0, 1'b0, 1'b0);
      send_word(9'h05A, 1'b1, 0, 1'b0, 1'b0);
      send_word(ck, 1'b1, 0, 1'b0, 1'b1);
      idle();
      if (expect_ok) begin
         run_cpu(2, 2);
      end else begin
         repeat (3) @(negedge clk);
         chk("cksum_error",     64'(error),     64'd1);
         chk("cksum_cpu_reset", 64'(cpu_reset), 64'd1);
         chk("cksum_busy",      64'(busy),      64'd0);
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int words[$];
      int acc;
      int n;

      reset = 1'b1; start = 1'b0; cpu_done = 1'b0;
      start_s = 1'b0; cpu_done_s = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
      bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
      chk("rst_wr_en",     64'(bus.wr_en),    64'd0);
      chk("rst_wr_addr",   64'(bus.wr_addr),  64'd0);
      chk("rst_wr_data",   64'(bus.wr_data),  64'd0);
      chk("rst_cpu_reset", 64'(cpu_reset),    64'd1);
      chk("rst_busy",      64'(busy),         64'd0);
      chk("rst_finished",  64'(finished),     64'd0);
      chk("rst_error",     64'(error),        64'd0);
      chk("rst_prog_len",  64'(prog_len),     64'd0);
      chk("rst_cycles",    64'(cycles),       64'd0);
      reset = 1'b0;

      // fixed four-word program, no back-pressure
      do_start();
      send_word(9'h041, 1'b0, 0, 1'b0, 1'b0);
      send_word(9'h082, 1'b0, 0, 1'b0, 1'b0);
      send_word(9'h0C3, 1'b0, 0, 1'b0, 1'b0);
      send_word(9'h000, 1'b1, 0, 1'b0, 1'b0);
      idle();
      chk("t1_prog_len", 64'(prog_len), 64'd4);
      chk("t1_busy",     64'(busy),     64'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
      chk("t1_check_ready",     64'(bus.in_ready), 64'd1);
      chk("t1_check_cpu_reset", 64'(cpu_reset),    64'd1);
      send_word(9'h000, 1'b0, 0, 1'b0, 1'b1);
      idle();
`else
      chk("t1_run_cpu_reset", 64'(cpu_reset),    64'd0);
      chk("t1_run_ready",     64'(bus.in_ready), 64'd0);
`endif
      run_cpu(1, 4);

      // valid toggling 1/0 over a three-word load
      words = {};
      for (int i = 0; i < 3; i++) words.push_back(int'($urandom_range(511)));
      load_program(words, 0, 1'b1);
      run_cpu(3, 3);

      // random programs with random gaps and run lengths
      for (int it = 0; it < 6; it++) begin
         n = int'($urandom_range(1, 24));
         words = {};
         for (int i = 0; i < n; i++) words.push_back(int'($urandom_range(511)));
         load_program(words, 30, 1'b0);
         run_cpu(int'($urandom_range(1, 15)), n);
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      checksum_case(9'h1FF, 1'b1);
      checksum_case(9'h000, 1'b0);
`endif

      // reset after two of five words, then reload from address 0
      do_start();
      words = {};
      for (int i = 0; i < 5; i++) words.push_back(int'($urandom_range(511)));
      send_word(words[0], 1'b0, 0, 1'b0, 1'b0);
      send_word(words[1], 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(words[2]);
      bus.in_last  = 1'b0;
      reset        = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_mid_wr_en",     64'(bus.wr_en),    64'd0);
      chk("rst_mid_in_ready",  64'(bus.in_ready), 64'd0);
      chk("rst_mid_busy",      64'(busy),         64'd0);
      chk("rst_mid_prog_len",  64'(prog_len),     64'd0);
      chk("rst_mid_cpu_reset", 64'(cpu_reset),    64'd1);
      words = words[2:4];
      load_program(words, 0, 1'b0);
      run_cpu(2, 3);

      // long run: saturation, ignored start during RUN
      words = '{int'($urandom_range(511))};
      load_program(words, 0, 1'b0);
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("run_start_ignored_cpu_reset", 64'(cpu_reset),    64'd0);
      chk("run_start_ignored_ready",     64'(bus.in_ready), 64'd0);
      chk("run_start_ignored_busy",      64'(busy),         64'd1);
      repeat (65600) @(negedge clk);
      chk("sat_cycles", 64'(cycles), 64'hFFFF);
      chk("sat_busy",   64'(busy),   64'd1);
      cpu_done = 1'b1;
      @(negedge clk);
      cpu_done = 1'b0;
      chk("sat_finished", 64'(finished), 64'd1);
      chk("sat_cycles_frozen", 64'(cycles), 64'hFFFF);
      $display("saturation: cycles=%0h", cycles);

      // reset during RUN
      words = '{int'($urandom_range(511))};
      load_program(words, 0, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_run_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("rst_run_cycles",    64'(cycles),    64'd0);
      chk("rst_run_busy",      64'(busy),      64'd0);

      // overflow on the D=3 instance: nine words offered, eight accepted
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      acc = 0;
      for (int c = 0; c < 20 && acc < 9; c++) begin
         @(negedge clk);
         bus_s.in_valid = 1'b1;
         bus_s.in_data  = W'(acc * 37 + 5);
         bus_s.in_last  = 1'b0;
         if (bus_s.in_ready === 1'b1) begin
            exp_s.push_back('{acc, acc * 37 + 5});
            acc++;
         end
      end
      @(negedge clk);
      bus_s.in_valid = 1'b0;
      chk("ovf_accepted",  64'(acc),          64'd8);
      chk("ovf_error",     64'(error_s),      64'd1);
      chk("ovf_cpu_reset", 64'(cpu_reset_s),  64'd1);
      chk("ovf_prog_len",  64'(prog_len_s),   64'd8);
      chk("ovf_busy",      64'(busy_s),       64'd0);
      chk("ovf_finished",  64'(finished_s),   64'd0);
      chk("ovf_cycles",    64'(cycles_s),     64'd0);

      repeat (3) @(negedge clk);
      chk("main_queue_empty",  64'(exp_q.size()), 64'd0);
      chk("small_queue_empty", 64'(exp_s.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter D, default 10, instruction-memory address width (matches the program counter width).
REQ-002 Parameter W, default 9, instruction word width.
REQ-003 clk  input  1  clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1  source presents a program word.
REQ-007 in_data  input  W  program word, or checksum word when in CHECK.
REQ-008 in_last  input  1  marks the final program word.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 wr_en  output  1  instruction-memory write strobe.
REQ-011 wr_addr  output  D  instruction-memory write address.
REQ-012 wr_data  output  W  instruction-memory write data.
REQ-013 cpu_reset  output  1  reset to the CPU core.
REQ-014 cpu_done  input  1  CPU done flag (high when the fetched machine code is all zeros).
REQ-015 busy  output  1  high in LOAD, CHECK and RUN.
REQ-016 finished  output  1  high in DONE.
REQ-017 error  output  1  high in ERR.
REQ-018 prog_len  output  D+1  number of words written by the last load.
REQ-019 cycles  output  16  CPU run-cycle count.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, CHECK, RUN, DONE and ERR; all outputs SHALL be registered.
REQ-021 A transfer SHALL occur when in_valid and in_ready are both high in the same cycle. in_ready SHALL be high only in LOAD and CHECK.
REQ-022 In IDLE, DONE or ERR, start=1 SHALL move the FSM to LOAD and clear the address counter, prog_len, cycles and error. start SHALL be ignored in every other state.
REQ-023 Each transfer in LOAD SHALL produce wr_en=1, wr_addr=counter and wr_data=in_data on the following cycle (one-cycle latency); the counter and prog_len then SHALL increment by 1.
REQ-024 wr_en SHALL be 0 in every cycle that does not follow a LOAD transfer.
REQ-025 A LOAD transfer with in_last=1 SHALL end the load: next state CHECK when PROG_LOADER_CHECKSUM_EN is defined, otherwise RUN.
REQ-026 A LOAD transfer at address 2^D-1 with in_last=0 SHALL still write that word, then enter ERR (overflow). The address SHALL never wrap.
REQ-027 cpu_reset SHALL be 1 in all states except RUN. It SHALL fall on the same edge that enters RUN and rise on the edge that leaves RUN.
REQ-028 In RUN, cycles SHALL increment once per clock and saturate at 16'hFFFF.
REQ-029 cpu_done SHALL be sampled only while cpu_reset=0. cpu_done=1 in RUN SHALL cause a transition to DONE, and cycles SHALL freeze at its current value.
REQ-030 DONE and ERR SHALL hold until start or reset. Memory contents are not touched after the load ends.

Reset
REQ-031 reset SHALL force state IDLE and in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, busy=0, finished=0, error=0, prog_len=0, cycles=0, checksum=0.
REQ-032 reset asserted mid-LOAD or mid-RUN SHALL abandon the operation, and SHALL suppress any pending wr_en in the cycle after reset.

Configuration
REQ-033 Macro PROG_LOADER_CHECKSUM_EN defined: a running W-bit XOR of all written words SHALL be kept. In CHECK, one transfer SHALL be compared against that XOR, and the compared word SHALL NOT be written. A match SHALL enter RUN; a mismatch SHALL enter ERR. in_last SHALL be ignored in CHECK.
REQ-034 Macro undefined: no CHECK state and no checksum register SHALL exist, and in_last SHALL go straight to RUN.

Verification
REQ-035 Load 4 words 0x041,0x082,0x0C3,0x000 (last on 4th), no back-pressure -> writes at addr 0..3 one cycle after each transfer, prog_len=4, then RUN. cpu_done held high -> DONE after 1 RUN cycle, cycles=1.
REQ-036 in_valid toggled 1/0 during a 3-word load -> exactly 3 wr_en pulses at addr 0,1,2, with no duplicate writes.
REQ-037 D=3, 9 words sent with no in_last -> 8 writes (addr 0..7), then error=1 and cpu_reset stays 1.
REQ-038 With CHECKSUM_EN: words 0x1A5,0x05A followed by checksum 0x1FF -> RUN. Repeat with checksum 0x000 -> ERR and no write of the checksum word.
REQ-039 reset asserted after 2 of 5 words -> IDLE, wr_en=0 next cycle. A new start then reloads from addr 0.
REQ-040 RUN with cpu_done=0 for 70000 cycles -> cycles=0xFFFF (saturated). A start pulse during RUN is ignored.
